j1_ram_arbiter: RTL and testbench

J1_RAM_ARBITER -- requirements
Module: j1_ram_arbiter

---
 rtl/j1_ram_arbiter.sv | 117 +++++++++++
 tb/tb_j1_ram_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/j1_ram_arbiter.sv
// Single-port RAM arbiter between the J1 CPU data port and a host loader.
// BOOT holds the CPU in reboot while the host owns the RAM; RUN favours the CPU with a host starvation limit.
module j1_ram_arbiter #(
  parameter int AW       = 9,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  output logic          cpu_pause,
  output logic          cpu_reboot,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  input  logic          boot_req,
  input  logic          boot_done,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic {ST_BOOT, ST_RUN} state_e;

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  state_e     state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       cpu_rvalid_q, cpu_rvalid_d;
  logic       host_rvalid_q, host_rvalid_d;
  logic       cpu_grant, host_grant;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    cpu_grant     = 1'b0;
    host_grant    = 1'b0;
    host_ready    = 1'b1;
    cpu_pause     = 1'b1;
    cpu_reboot    = 1'b1;
    ram_en        = 1'b0;
    ram_we        = 1'b0;
    ram_addr      = '0;
    ram_wdata     = '0;

    unique case (state_q)
      ST_BOOT: begin
        host_grant = host_valid;
        if (boot_done) state_d = ST_RUN;
      end
      ST_RUN: begin
        cpu_reboot = 1'b0;
        host_ready = !cpu_req || (wait_cnt_q == WAIT_LIMIT);
        host_grant = host_valid && host_ready;
        cpu_grant  = cpu_req && !host_grant;
        cpu_pause  = cpu_req && host_grant;
        if (host_valid && !host_ready && (wait_cnt_q != WAIT_LIMIT))
          wait_cnt_d = wait_cnt_q + 4'd1;
        if (boot_req) state_d = ST_BOOT;
      end
      default: state_d = ST_BOOT;
    endcase

    // A handshake or a fresh BOOT entry restarts the starvation count.
    if (host_grant || (state_d == ST_BOOT && state_q == ST_RUN))
      wait_cnt_d = 4'd0;

    if (host_grant) begin
      ram_en    = 1'b1;
      ram_we    = host_we;
      ram_addr  = host_addr;
      ram_wdata = host_wdata;
    end else if (cpu_grant) begin
      ram_en    = 1'b1;
      ram_we    = cpu_we;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end

    // Reads complete one cycle later regardless of a BOOT/RUN change in between.
    cpu_rvalid_d  = cpu_grant && !cpu_we;
    host_rvalid_d = host_grant && !host_we;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q       <= ST_BOOT;
      wait_cnt_q    <= 4'd0;
      cpu_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      host_rvalid_q <= host_rvalid_d;
    end
  end

  assign cpu_rvalid  = cpu_rvalid_q;
  assign host_rvalid = host_rvalid_q;
  assign cpu_rdata   = ram_rdata;
  assign host_rdata  = ram_rdata;

endmodule

// File: tb/tb_j1_ram_arbiter.sv
// Randomised and directed bench for j1_ram_arbiter against a transaction-level model of the arbitration rules.
module tb_j1_ram_arbiter;

  localparam int AW = 9;
  localparam int DW = 16;
  localparam int MAX_WAIT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_rvalid, cpu_pause, cpu_reboot;
  logic          host_valid, host_ready, host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic          host_rvalid;
  logic          boot_req, boot_done;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  int total = 0;
  int bad   = 0;

  j1_ram_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_pause(cpu_pause), .cpu_reboot(cpu_reboot),
    .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .boot_req(boot_req), .boot_done(boot_done),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM attached to the arbiter port.
  logic [DW-1:0] ram_mem [1<<AW];
  initial for (int i = 0; i < (1<<AW); i++) ram_mem[i] = '0;
  always @(posedge clk) begin
    if (ram_en === 1'b1) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram_mem[ram_addr];
    end
  end

  // Reference model: who owns the RAM this cycle, what the RAM holds, and which replies are due.
  bit            m_boot;
  int            m_starve;
  bit            m_cpu_rv, m_host_rv;
  logic [DW-1:0] m_cpu_data, m_host_data;
  logic [DW-1:0] shadow [1<<AW];
  bit            e_ready, e_pause, e_reboot, e_hgo, e_cgo;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_compare();
    if (m_boot) begin
      e_ready = 1; e_pause = 1; e_reboot = 1;
      e_hgo = host_valid; e_cgo = 0;
    end else begin
      e_reboot = 0;
      e_ready  = !cpu_req || (m_starve == MAX_WAIT);
      e_hgo    = host_valid && e_ready;
      e_cgo    = cpu_req && !e_hgo;
      e_pause  = cpu_req && e_hgo;
    end
    check("host_ready", 32'(host_ready), 32'(e_ready));
    check("cpu_pause",  32'(cpu_pause),  32'(e_pause));
    check("cpu_reboot", 32'(cpu_reboot), 32'(e_reboot));
    check("ram_en",     32'(ram_en),     32'(e_hgo || e_cgo));
    if (e_hgo) begin
      check("ram_we(host)", 32'(ram_we), 32'(host_we));
      check("ram_addr(host)", 32'(ram_addr), 32'(host_addr));
      if (host_we) check("ram_wdata(host)", 32'(ram_wdata), 32'(host_wdata));
    end else if (e_cgo) begin
      check("ram_we(cpu)", 32'(ram_we), 32'(cpu_we));
      check("ram_addr(cpu)", 32'(ram_addr), 32'(cpu_addr));
      if (cpu_we) check("ram_wdata(cpu)", 32'(ram_wdata), 32'(cpu_wdata));
    end else begin
      check("ram_we(idle)", 32'(ram_we), 32'd0);
    end
    check("cpu_rvalid",  32'(cpu_rvalid),  32'(m_cpu_rv));
    check("host_rvalid", 32'(host_rvalid), 32'(m_host_rv));
    if (m_cpu_rv)  check("cpu_rdata",  32'(cpu_rdata),  32'(m_cpu_data));
    if (m_host_rv) check("host_rdata", 32'(host_rdata), 32'(m_host_data));
  endtask

  task automatic model_update();
    m_cpu_rv  = e_cgo && !cpu_we;
    m_host_rv = e_hgo && !host_we;
    if (e_hgo) begin
      if (host_we) shadow[host_addr] = host_wdata;
      else         m_host_data = shadow[host_addr];
    end else if (e_cgo) begin
      if (cpu_we) shadow[cpu_addr] = cpu_wdata;
      else        m_cpu_data = shadow[cpu_addr];
    end
    if (e_hgo) m_starve = 0;
    else if (!m_boot && host_valid && !e_ready && m_starve < MAX_WAIT) m_starve++;
    if (m_boot) begin
      if (boot_done) m_boot = 0;
    end else if (boot_req) begin
      m_boot = 1; m_starve = 0;
    end
    if (reset) begin
      m_boot = 1; m_starve = 0; m_cpu_rv = 0; m_host_rv = 0;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_compare();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cycle();
    settle();
    tick();
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    host_valid = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    boot_req = 0; boot_done = 0;
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_valid = 1; host_we = 1; host_addr = a; host_wdata = d;
    cycle();
    host_valid = 0; host_we = 0;
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) shadow[i] = '0;
    e_ready = 0; e_pause = 0; e_reboot = 0; e_hgo = 0; e_cgo = 0;
    m_cpu_data = '0; m_host_data = '0;
    idle_inputs();
    reset = 1;
    #1;
    tick();
    cycle();
    reset = 0;

    // Reset values.
    settle();
    check("rst cpu_reboot", 32'(cpu_reboot), 32'd1);
    check("rst cpu_pause", 32'(cpu_pause), 32'd1);
    check("rst host_ready", 32'(host_ready), 32'd1);
    check("rst ram_en", 32'(ram_en), 32'd0);
    check("rst rvalids", 32'({cpu_rvalid, host_rvalid}), 32'd0);
    tick();

    // Boot load and CPU read-back.
    host_write(9'h000, 16'h1234);
    host_write(9'h1FF, 16'hBEEF);
    host_write(9'h010, 16'h5A5A);
    boot_done = 1;
    cycle();
    boot_done = 0;
    settle();
    check("boot released", 32'(cpu_reboot), 32'd0);
    tick();
    cpu_req = 1; cpu_we = 0; cpu_addr = 9'h1FF;
    cycle();
    cpu_req = 0;
    settle();
    check("boot rvalid", 32'(cpu_rvalid), 32'd1);
    check("boot rdata", 32'(cpu_rdata), 32'h0000BEEF);
    tick();

    // Contention: host granted on the fifth cycle of waiting.
    cpu_req = 1; cpu_we = 0; cpu_addr = 9'h000;
    host_valid = 1; host_we = 0; host_addr = 9'h010;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("cont host_ready", 32'(host_ready), 32'(i == 4));
      check("cont cpu_pause", 32'(cpu_pause), 32'(i == 4));
      tick();
    end
    settle();
    check("cont restart", 32'(host_ready), 32'd0);
    check("cont host_rvalid", 32'(host_rvalid), 32'd1);
    check("cont host_rdata", 32'(host_rdata), 32'h00005A5A);
    tick();
    idle_inputs();
    cycle();

    // Idle CPU: host served immediately.
    host_valid = 1; host_we = 0; host_addr = 9'h010;
    settle();
    check("idle host_ready", 32'(host_ready), 32'd1);
    check("idle cpu_pause", 32'(cpu_pause), 32'd0);
    tick();
    host_valid = 0;
    settle();
    check("idle host_rvalid", 32'(host_rvalid), 32'd1);
    check("idle host_rdata", 32'(host_rdata), 32'h00005A5A);
    tick();

    // Reload with a CPU read in flight.
    cpu_req = 1; cpu_we = 0; cpu_addr = 9'h000; boot_req = 1;
    cycle();
    cpu_req = 0; boot_req = 0;
    settle();
    check("reload rvalid", 32'(cpu_rvalid), 32'd1);
    check("reload rdata", 32'(cpu_rdata), 32'h00001234);
    check("reload reboot", 32'(cpu_reboot), 32'd1);
    check("reload pause", 32'(cpu_pause), 32'd1);
    check("reload ready", 32'(host_ready), 32'd1);
    tick();

    // boot_req with boot_done in RUN goes to BOOT; boot_done alone in RUN does nothing.
    boot_done = 1;
    cycle();
    boot_req = 1; boot_done = 1;
    cycle();
    boot_req = 0; boot_done = 0;
    settle();
    check("req+done -> boot", 32'(cpu_reboot), 32'd1);
    tick();
    boot_done = 1;
    cycle();
    cycle();
    boot_done = 0;
    settle();
    check("done in run ignored", 32'(cpu_reboot), 32'd0);
    tick();

    // Reset in the same cycle a host read is granted cancels its reply.
    host_valid = 1; host_we = 0; host_addr = 9'h1FF; reset = 1;
    cycle();
    host_valid = 0; reset = 0;
    settle();
    check("rst-read host_rvalid", 32'(host_rvalid), 32'd0);
    check("rst-read reboot", 32'(cpu_reboot), 32'd1);
    check("rst-read ready", 32'(host_ready), 32'd1);
    check("rst-read ram_en", 32'(ram_en), 32'd0);
    tick();

    // Randomised traffic.
    boot_done = 1;
    cycle();
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(0, 199) == 0);
      boot_req   = ($urandom_range(0, 59) == 0);
      boot_done  = ($urandom_range(0, 7) == 0);
      cpu_req    = ($urandom_range(0, 9) < 7);
      cpu_we     = $urandom_range(0, 1);
      cpu_addr   = AW'($urandom);
      cpu_wdata  = DW'($urandom);
      host_valid = $urandom_range(0, 1);
      host_we    = $urandom_range(0, 1);
      host_addr  = AW'($urandom);
      host_wdata = DW'($urandom);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
